seq_pattern_gen: RTL and testbench

//  Serial bit-pattern transmitter: the source side of our serial sequence detectors.

---
 rtl/seq_pattern_gen.sv | 150 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial bit-pattern transmitter. Shifts a PAT_W-bit pattern out
//            MSB-first, repeats it a captured number of times with an
//            optional idle gap between repetitions, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_gap   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [IDX_W-1:0] c_msb_idx = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] c_one_rep = CNT_W'(1);

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_reps;      // repetitions still to send, including current
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_gap_cnt;   // gap cycles left, including the one on the line
    logic [IDX_W-1:0] r_bit_idx;   // index of the bit currently on x_out

    logic [IDX_W-1:0] w_idx_dec;
    logic             w_last_bit;
    logic             w_more_reps;

    // Next bit index and end-of-repetition decisions for the shifter
    always_comb begin
        w_idx_dec   = r_bit_idx - IDX_W'(1);
        w_last_bit  = (r_bit_idx == '0);
        w_more_reps = (r_reps > c_one_rep);
    end

    // Burst sequencer; every output is registered so it reflects the state entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_pat     <= '0;
            r_reps    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_bit_idx <= '0;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    x_out     <= 1'b0;
                    x_valid   <= 1'b0;
                    frame_end <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        r_pat     <= pattern;
                        // A zero repeat count still sends the pattern once
                        r_reps    <= (repeat_cnt == '0) ? c_one_rep : repeat_cnt;
                        r_gap     <= gap;
                        r_bit_idx <= c_msb_idx;
                        r_state   <= c_shift;
                        x_out     <= pattern[PAT_W-1];
                        x_valid   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                c_shift: begin
                    if (!w_last_bit) begin
                        r_bit_idx <= w_idx_dec;
                        x_out     <= r_pat[w_idx_dec];
                        x_valid   <= 1'b1;
                        frame_end <= (w_idx_dec == '0);
                    end else if (w_more_reps) begin
                        r_reps <= r_reps - c_one_rep;
                        if (r_gap == '0) begin
                            // Back-to-back repetition: next MSB with no bubble
                            r_bit_idx <= c_msb_idx;
                            x_out     <= r_pat[PAT_W-1];
                            x_valid   <= 1'b1;
                            frame_end <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap;
                            r_state   <= c_gap;
                            x_out     <= 1'b0;
                            x_valid   <= 1'b0;
                            frame_end <= 1'b0;
                        end
                    end else begin
                        r_state   <= c_done;
                        x_out     <= 1'b0;
                        x_valid   <= 1'b0;
                        frame_end <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                c_gap: begin
                    if (r_gap_cnt == c_one_rep) begin
                        r_bit_idx <= c_msb_idx;
                        r_state   <= c_shift;
                        x_out     <= r_pat[PAT_W-1];
                        x_valid   <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_one_rep;
                    end
                end

                c_done: begin
                    // start is deliberately not sampled here
                    r_state <= c_idle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end

                default: begin
                    r_state   <= c_idle;
                    x_out     <= 1'b0;
                    x_valid   <= 1'b0;
                    frame_end <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Self-checking bench for seq_pattern_gen: table of bursts with
//            expected summary figures, per-cycle reference stream, random
//            bursts with mid-burst input noise, reset abort and held start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap;
    logic             x_out, x_valid, frame_end, busy, done;

    int vectors = 0;
    int miscompares = 0;

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .frame_end  (frame_end),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PAT_W-1:0] pat;
        int               reps;
        int               gp;
        int               exp_bits;
        int               exp_fe;
        int               exp_ones;
        int               exp_done_cyc;
        int               exp_det;
    } vec_t;

    // Output bundle order: {x_out, x_valid, frame_end, busy, done}
    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {x_out, x_valid, frame_end, busy, done};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {x,v,fe,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one burst and checks every cycle against a stream built from the
    // burst rules; returns figures measured on the DUT outputs.
    task automatic run_burst(input logic [PAT_W-1:0] pat, input int reps, input int gp,
                             input bit inject,
                             output int nbits, output int nfe, output int nones,
                             output int done_cyc, output int ndet);
        logic [4:0] exp_q[$];
        logic [3:0] win;
        int eff;
        eff = (reps == 0) ? 1 : reps;
        exp_q = {};
        for (int r = 0; r < eff; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (r < eff - 1)
                for (int g = 0; g < gp; g++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);

        nbits = 0; nfe = 0; nones = 0; done_cyc = 0; ndet = 0; win = '0;
        pattern    = pat;
        repeat_cnt = CNT_W'(reps);
        gap        = CNT_W'(gp);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("burst p=%h r=%0d g=%0d cyc%0d", pat, reps, gp, i + 1), exp_q[i]);
            if (x_valid) nbits++;
            if (frame_end) nfe++;
            if (x_valid && x_out) nones++;
            if (done && done_cyc == 0) done_cyc = i + 1;
            if (busy && !done) begin
                win = {win[2:0], x_out};
                if (win == 4'b1010) ndet++;
            end
            if (i < exp_q.size() - 1) begin
                if (inject) begin
                    start      = 1'($urandom);
                    pattern    = PAT_W'($urandom);
                    repeat_cnt = CNT_W'($urandom);
                    gap        = CNT_W'($urandom);
                end
                tick();
            end
        end
        start = 1'b0;
    endtask

    vec_t tbl[8];
    int nbits, nfe, nones, dcyc, ndet;

    initial begin
        tbl[0] = '{4'hA,   1, 0,    4,   1,   2,    5, 1};
        tbl[1] = '{4'hA,   3, 0,   12,   3,   6,   13, 5};
        tbl[2] = '{4'hA,   2, 3,    8,   2,   4,   12, 2};
        tbl[3] = '{4'hC,   0, 0,    4,   1,   2,    5, 0};
        tbl[4] = '{4'hF,   2, 1,    8,   2,   8,   10, 0};
        tbl[5] = '{4'h1,   4, 2,   16,   4,   4,   23, 0};
        tbl[6] = '{4'h0, 255, 0, 1020, 255,   0, 1021, 0};
        tbl[7] = '{4'h3, 255, 1, 1020, 255, 510, 1275, 0};

        rst = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
        #1;
        chk("reset state", 5'b00000);
        tick(); tick();
        chk("reset state held", 5'b00000);
        rst = 1'b0;
        tick();
        chk("idle after reset", 5'b00000);

        // Table-driven bursts
        for (int k = 0; k < 8; k++) begin
            run_burst(tbl[k].pat, tbl[k].reps, tbl[k].gp, k[0], nbits, nfe, nones, dcyc, ndet);
            chk_int($sformatf("row%0d valid bits", k), nbits, tbl[k].exp_bits);
            chk_int($sformatf("row%0d frame_end count", k), nfe, tbl[k].exp_fe);
            chk_int($sformatf("row%0d ones", k), nones, tbl[k].exp_ones);
            chk_int($sformatf("row%0d done cycle", k), dcyc, tbl[k].exp_done_cyc);
            chk_int($sformatf("row%0d 1010 detections", k), ndet, tbl[k].exp_det);
        end

        // Reset in the middle of a 4-repetition burst
        pattern = 4'hB; repeat_cnt = 8'd4; gap = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("async reset mid-burst", 5'b00000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("idle after abort cyc%0d", i), 5'b00000);
        end
        run_burst(4'h6, 1, 0, 1'b0, nbits, nfe, nones, dcyc, ndet);
        chk_int("post-abort done cycle", dcyc, 5);

        // start held high: ignored while busy and in DONE, restarts from IDLE
        pattern = 4'hD; repeat_cnt = 8'd1; gap = 8'd0; start = 1'b1;
        tick();
        chk("held start cyc1", 5'b11010);
        for (int i = 2; i <= 4; i++) tick();
        chk("held start cyc4", 5'b11110);
        tick();
        chk("held start done", 5'b00011);
        tick();
        chk("held start idle gap", 5'b00000);
        tick();
        chk("held start restart", 5'b11010);
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("after restart burst", 5'b00000);

        // Random bursts with noise on inputs during the burst
        for (int k = 0; k < 25; k++) begin
            run_burst(PAT_W'($urandom), $urandom_range(0, 5), $urandom_range(0, 3), 1'b1,
                      nbits, nfe, nones, dcyc, ndet);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
